// File: rtl/risc_trace_mon.sv
// State-change monitor: compares a watched bus against a shadow copy and emits one
// {channel, value, timestamp} record per changed word through a show-ahead FIFO.
module risc_trace_mon #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int DEPTH    = 8,
    parameter int CYCW     = 16,
    parameter int DROP     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [CHANNELS*WIDTH-1:0]     snap_bus,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(CHANNELS)-1:0]   out_idx,
    output logic [WIDTH-1:0]              out_data,
    output logic [CYCW-1:0]               out_cycle,
    output logic                          busy,
    output logic                          overflow,
    output logic [CYCW-1:0]               drop_count
);

    localparam int IDXW = $clog2(CHANNELS);
    localparam int AW   = $clog2(DEPTH);
    localparam int RECW = IDXW + WIDTH + CYCW;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                           state_q, state_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   shadow_q, shadow_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   hold_q, hold_d;
    logic [CHANNELS-1:0]              mask_q, mask_d;
    logic [CYCW-1:0]                  cap_ts_q, cap_ts_d;
    logic [CYCW-1:0]                  ts_q;
    logic                             overflow_q, overflow_d;
    logic [CYCW-1:0]                  drop_q, drop_d;

    logic [CHANNELS-1:0][WIDTH-1:0]   snap_w;
    logic [CHANNELS-1:0]              diff;
    logic [CHANNELS-1:0]              mask_rest;
    logic [IDXW-1:0]                  sel_idx;

    logic [RECW-1:0]                  mem_q [DEPTH];
    logic [AW-1:0]                    wr_ptr_q, rd_ptr_q;
    logic [AW:0]                      count_q;
    logic [RECW-1:0]                  head;
    logic                             fifo_full, push, pop, space;

    assign snap_w = snap_bus;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_diff
            assign diff[gi] = (snap_w[gi] != shadow_q[gi]);
        end
    endgenerate

    // Lowest pending channel is serviced first so records come out in index order.
    always_comb begin
        sel_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (mask_q[k]) sel_idx = IDXW'(k);
        end
    end

    assign mask_rest = mask_q & (mask_q - CHANNELS'(1));

    assign fifo_full = (count_q == (AW+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign space     = ~fifo_full | pop;

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        hold_d     = hold_q;
        mask_d     = mask_q;
        cap_ts_d   = cap_ts_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (diff != '0)) begin
                    hold_d   = snap_w;
                    mask_d   = diff;
                    cap_ts_d = ts_q;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (space || (DROP != 0)) begin
                    push = space;
                    if (!space) begin
                        overflow_d = 1'b1;
                        if (drop_q != '1) drop_d = drop_q + CYCW'(1);
                    end
                    shadow_d[sel_idx] = hold_q[sel_idx];
                    mask_d            = mask_rest;
                    if (mask_rest == '0) state_d = IDLE;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d    = IDLE;
            mask_d     = '0;
            shadow_d   = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
            push       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            hold_q     <= '0;
            mask_q     <= '0;
            cap_ts_q   <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            hold_q     <= hold_d;
            mask_q     <= mask_d;
            cap_ts_q   <= cap_ts_d;
            ts_q       <= ts_q + CYCW'(1);
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Record storage carries no reset; entries are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {sel_idx, hold_q[sel_idx], cap_ts_q};
    end

    assign head       = mem_q[rd_ptr_q];
    assign out_idx    = out_valid ? head[RECW-1 -: IDXW]        : '0;
    assign out_data   = out_valid ? head[CYCW +: WIDTH]         : '0;
    assign out_cycle  = out_valid ? head[CYCW-1:0]              : '0;
    assign busy       = (state_q == SCAN);
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_risc_trace_mon.sv
// Bench for risc_trace_mon: a stalling and a dropping instance share stimulus and are
// compared every cycle against a queue/array reference model of the capture rules.
module tb_risc_trace_mon;

    localparam int W  = 16;
    localparam int CH = 16;
    localparam int D  = 8;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              enable = 1'b0;
    logic              clear = 1'b0;
    logic              out_ready = 1'b0;
    logic [CH*W-1:0]   snap_bus = '0;

    logic              o_valid [2];
    logic [3:0]        o_idx   [2];
    logic [W-1:0]      o_data  [2];
    logic [CW-1:0]     o_cycle [2];
    logic [CW-1:0]     o_drops [2];
    logic              o_busy  [2];
    logic              o_ovf   [2];

    always #5 clk = ~clk;

    risc_trace_mon #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .CYCW(CW), .DROP(0)) u_stall (
        .clk(clk), .rst(rst_n), .enable(enable), .clear(clear), .snap_bus(snap_bus),
        .out_valid(o_valid[0]), .out_ready(out_ready), .out_idx(o_idx[0]),
        .out_data(o_data[0]), .out_cycle(o_cycle[0]), .busy(o_busy[0]),
        .overflow(o_ovf[0]), .drop_count(o_drops[0]));

    risc_trace_mon #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .CYCW(CW), .DROP(1)) u_drop (
        .clk(clk), .rst(rst_n), .enable(enable), .clear(clear), .snap_bus(snap_bus),
        .out_valid(o_valid[1]), .out_ready(out_ready), .out_idx(o_idx[1]),
        .out_data(o_data[1]), .out_cycle(o_cycle[1]), .busy(o_busy[1]),
        .overflow(o_ovf[1]), .drop_count(o_drops[1]));

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state, index 0 = stalling instance, 1 = dropping instance.
    logic [CW-1:0]  m_ts;
    logic [W-1:0]   m_shadow [2][CH];
    logic [W-1:0]   m_hold   [2][CH];
    int             m_pend   [2][CH];
    int             m_pn [2], m_pr [2];
    bit             m_scan [2];
    logic [CW-1:0]  m_cap [2];
    bit             m_ovf [2];
    int             m_drops [2];
    bit             m_pushed [2];
    logic [3:0]     f_idx [2][D];
    logic [W-1:0]   f_dat [2][D];
    logic [CW-1:0]  f_cyc [2][D];
    int             f_head [2], f_cnt [2];

    logic [CH*W-1:0] cur;
    int              rc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ts = '0;
        for (int i = 0; i < 2; i++) begin
            m_scan[i] = 0; f_head[i] = 0; f_cnt[i] = 0;
            m_ovf[i] = 0; m_drops[i] = 0; m_pushed[i] = 0;
            for (int k = 0; k < CH; k++) m_shadow[i][k] = '0;
        end
    endtask

    task automatic model_step(input int i, input bit en, input bit clr, input bit rdy,
                              input logic [CH*W-1:0] snap);
        bit pop, space;
        int k, slot;
        pop   = rdy && (f_cnt[i] > 0);
        space = (f_cnt[i] < D) || pop;
        if (clr) begin
            f_head[i] = 0; f_cnt[i] = 0; m_scan[i] = 0; m_ovf[i] = 0; m_drops[i] = 0;
            for (int c = 0; c < CH; c++) m_shadow[i][c] = '0;
            return;
        end
        if (pop) begin
            f_head[i] = (f_head[i] + 1) % D;
            f_cnt[i]--;
        end
        if (!m_scan[i]) begin
            if (en) begin
                m_pn[i] = 0;
                for (int c = 0; c < CH; c++) begin
                    if (snap[c*W +: W] != m_shadow[i][c]) begin
                        m_pend[i][m_pn[i]] = c;
                        m_pn[i]++;
                    end
                end
                if (m_pn[i] > 0) begin
                    for (int c = 0; c < CH; c++) m_hold[i][c] = snap[c*W +: W];
                    m_cap[i]  = m_ts;
                    m_pr[i]   = 0;
                    m_scan[i] = 1;
                end
            end
        end else begin
            k = m_pend[i][m_pr[i]];
            if (space) begin
                slot = (f_head[i] + f_cnt[i]) % D;
                f_idx[i][slot] = 4'(k);
                f_dat[i][slot] = m_hold[i][k];
                f_cyc[i][slot] = m_cap[i];
                f_cnt[i]++;
                m_pushed[i] = 1;
            end else begin
                m_ovf[i] = 1;
                if (i == 1 && m_drops[i] < 65535) m_drops[i]++;
            end
            if (space || i == 1) begin
                m_shadow[i][k] = m_hold[i][k];
                m_pr[i]++;
                if (m_pr[i] == m_pn[i]) m_scan[i] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("valid%0d", i), o_valid[i], f_cnt[i] > 0);
            if (f_cnt[i] > 0) begin
                check($sformatf("idx%0d", i),   o_idx[i],   f_idx[i][f_head[i]]);
                check($sformatf("data%0d", i),  o_data[i],  f_dat[i][f_head[i]]);
                check($sformatf("cycle%0d", i), o_cycle[i], f_cyc[i][f_head[i]]);
            end else if (!m_pushed[i]) begin
                check($sformatf("idx_empty%0d", i),  o_idx[i],   0);
                check($sformatf("data_empty%0d", i), o_data[i],  0);
                check($sformatf("cyc_empty%0d", i),  o_cycle[i], 0);
            end
            check($sformatf("busy%0d", i),  o_busy[i],  m_scan[i]);
            check($sformatf("ovf%0d", i),   o_ovf[i],   m_ovf[i]);
            check($sformatf("drops%0d", i), o_drops[i], m_drops[i]);
        end
    endtask

    // Entered and left at a falling edge; covers exactly one rising edge.
    task automatic step(input bit en, input bit clr, input bit rdy, input logic [CH*W-1:0] snap);
        check_outputs();
        enable = en; clear = clr; out_ready = rdy; snap_bus = snap;
        model_step(0, en, clr, rdy, snap);
        model_step(1, en, clr, rdy, snap);
        m_ts = m_ts + 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_busy0",  o_busy[0],  0);
        check("rst_valid0", o_valid[0], 0);
        check("rst_busy1",  o_busy[1],  0);
        check("rst_valid1", o_valid[1], 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        cur = '0;
        @(negedge clk);
        do_reset();

        // Quiet bus: nothing to report.
        repeat (5) step(1, 0, 1, cur);

        // Two channels change together at ts=5.
        cur[3*W +: W] = 16'h00A5;
        cur[9*W +: W] = 16'h1234;
        step(1, 0, 0, cur);
        check("cap_busy0", o_busy[0], 1);
        step(1, 0, 0, cur);
        check("rec0_valid", o_valid[0], 1);
        check("rec0_idx",   o_idx[0],   3);
        check("rec0_data",  o_data[0],  16'h00A5);
        check("rec0_cycle", o_cycle[0], 5);
        step(1, 0, 0, cur);
        check("scan2_busy_low", o_busy[0], 0);
        repeat (4) step(1, 0, 1, cur);

        // Every channel changes with the consumer stalled.
        for (int k = 0; k < CH; k++) cur[k*W +: W] = 16'h1000 + 16'(k);
        repeat (20) step(1, 0, 0, cur);
        check("stall_busy",  o_busy[0],  1);
        check("stall_ovf",   o_ovf[0],   1);
        check("drop_busy",   o_busy[1],  0);
        check("drop_count8", o_drops[1], 8);
        check("drop_ovf",    o_ovf[1],   1);
        repeat (40) step(1, 0, 1, cur);
        check("stall_drops0", o_drops[0], 0);

        // R0 changes again while its first change is still being scanned.
        cur[0*W +: W] = 16'h0001;
        cur[1*W +: W] = 16'h2001;
        cur[2*W +: W] = 16'h2002;
        step(1, 0, 1, cur);
        cur[0*W +: W] = 16'h0002;
        repeat (10) step(1, 0, 1, cur);

        // Clear with four records queued and a scan running.
        for (int k = 0; k < CH; k++) cur[k*W +: W] = 16'h3000 + 16'(k);
        repeat (5) step(1, 0, 0, cur);
        step(1, 1, 0, cur);
        check("clr_valid0", o_valid[0], 0);
        check("clr_busy0",  o_busy[0],  0);
        check("clr_ovf0",   o_ovf[0],   0);
        check("clr_ovf1",   o_ovf[1],   0);
        repeat (24) step(1, 0, 1, cur);

        // Reset in the middle of a scan.
        for (int k = 4; k < 9; k++) cur[k*W +: W] = 16'h4000 + 16'(k);
        repeat (3) step(1, 0, 1, cur);
        do_reset();
        repeat (24) step(1, 0, 1, cur);

        // Random traffic on a narrow value range so re-writes of equal values occur.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    rc = int'($urandom_range(0, CH - 1));
                    cur[rc*W +: W] = 16'($urandom_range(0, 3));
                end
            end
            step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0, cur);
        end
        repeat (30) step(1, 0, 1, cur);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
